// File: rtl/hog_pkg.sv
// HOG shared definitions: bin-boundary constants, default widths, bin count.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Shared by the divider clamp, this bin accumulator and block normalisation.
package hog_pkg;

   localparam int HOG_TAN_W = 20;   // Q4.16 signed gy/gx ratio
   localparam int HOG_ACC_W = 24;   // per-bin accumulator width
   localparam int NUM_BINS  = 9;    // 20-degree unsigned-orientation bins
   localparam int BIN_W     = 4;    // enough to index NUM_BINS

   // tan() of the bin edges in Q4.16. T80 and T100 double as the divider's
   // clamp limits, so |angle| near 90 degrees always lands in bin 4.
   localparam logic signed [HOG_TAN_W-1:0] T20  = 20'sh05D2D;
   localparam logic signed [HOG_TAN_W-1:0] T40  = 20'sh0D6D0;
   localparam logic signed [HOG_TAN_W-1:0] T60  = 20'sh1BB68;
   localparam logic signed [HOG_TAN_W-1:0] T80  = 20'sh5ABD9;
   localparam logic signed [HOG_TAN_W-1:0] T100 = 20'shA5426;
   localparam logic signed [HOG_TAN_W-1:0] T120 = 20'shE4498;
   localparam logic signed [HOG_TAN_W-1:0] T140 = 20'shF2930;
   localparam logic signed [HOG_TAN_W-1:0] T160 = 20'shFA2D3;

   typedef enum logic {
      ST_ACC  = 1'b0,   // accepting samples of the current cell
      ST_WAIT = 1'b1    // cell complete, waiting to hand off the histogram
   } acc_state_e;

endpackage

// File: rtl/hog_bin_sel.sv
// Combinational tan-to-orientation-bin comparator.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: tan  - signed Q4.16 ratio, pre-clamped to [T100, T80]
//        bin  - orientation bin 0..8
module hog_bin_sel
   import hog_pkg::*;
#(
   parameter int TAN_W = HOG_TAN_W
) (
   input  logic signed [TAN_W-1:0] tan,
   output logic [BIN_W-1:0]        bin
);

   // Non-negative ratios are half-open on the upper edge; negative ratios are
   // half-open on the lower edge, so each edge angle belongs to the bin whose
   // angle range starts there.
   always_comb begin
      bin = '0;
      if (!tan[TAN_W-1]) begin
         if      (tan < T20) bin = 4'd0;
         else if (tan < T40) bin = 4'd1;
         else if (tan < T60) bin = 4'd2;
         else if (tan < T80) bin = 4'd3;
         else                bin = 4'd4;
      end else begin
         if      (tan <= T100) bin = 4'd4;
         else if (tan <= T120) bin = 4'd5;
         else if (tan <= T140) bin = 4'd6;
         else if (tan <= T160) bin = 4'd7;
         else                  bin = 4'd8;
      end
   end

endmodule

// File: rtl/hog_bin_accum.sv
// HOG cell histogram: bins each (tan, mag) sample and accumulates mag per bin.
// Latency: last sample of a cell transferred at t -> o_valid at t+2 if output free.
// Backpressure: i_ready drops after a full cell until the histogram is handed off.
// Ports: clk/rst_n          - clock, async active-low reset
//        i_valid/i_ready    - sample handshake; i_tan (Q4.16), i_mag (unsigned)
//        o_valid/o_ready    - histogram handshake; o_hist bin k at [k*ACC_W +: ACC_W]
//        o_drop             - sticky: a sample was offered while i_ready=0
module hog_bin_accum
   import hog_pkg::*;
#(
   parameter int TAN_W    = HOG_TAN_W,
   parameter int MAG_W    = 16,
   parameter int ACC_W    = HOG_ACC_W,
   parameter int CELL_PIX = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_valid,
   output logic                      i_ready,
   input  logic [TAN_W-1:0]          i_tan,
   input  logic [MAG_W-1:0]          i_mag,
   output logic                      o_valid,
   input  logic                      o_ready,
   output logic [NUM_BINS*ACC_W-1:0] o_hist,
   output logic                      o_drop
);

   localparam int               CNT_W    = $clog2(CELL_PIX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_PIX - 1);

   acc_state_e state_q, state_d;

   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      s1_vld_q, s1_vld_d;
   logic [BIN_W-1:0]          s1_bin_q, s1_bin_d;
   logic [MAG_W-1:0]          s1_mag_q, s1_mag_d;
   logic [ACC_W-1:0]          acc_q   [NUM_BINS];
   logic [ACC_W-1:0]          acc_d   [NUM_BINS];
   logic [ACC_W-1:0]          acc_sum [NUM_BINS];
   logic [NUM_BINS*ACC_W-1:0] o_hist_q, o_hist_d;
   logic                      o_valid_q, o_valid_d;
   logic                      o_drop_q, o_drop_d;

   logic             xfer;
   logic             cell_done;
   logic             handoff;
   logic [BIN_W-1:0] bin_w;
   logic [ACC_W-1:0] mag_ext;

   hog_bin_sel #(.TAN_W(TAN_W)) u_bin_sel (
      .tan (i_tan),
      .bin (bin_w)
   );

   assign xfer      = i_valid && i_ready;
   assign cell_done = xfer && (cnt_q == CNT_LAST);
   assign mag_ext   = ACC_W'(s1_mag_q);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_ACC;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACC:  if (cell_done) state_d = ST_WAIT;
         ST_WAIT: if (handoff)   state_d = ST_ACC;
         default: state_d = ST_ACC;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // i_ready is gated by rst_n so it reads 0 for the whole reset assertion.
   // In WAIT the last sample is either still in stage 1 (first WAIT cycle) or
   // already in the accumulators; acc_sum covers both, so hand-off is legal on
   // any WAIT cycle where the output register is free or being drained.
   always_comb begin
      i_ready = 1'b0;
      handoff = 1'b0;
      case (state_q)
         ST_ACC:  i_ready = rst_n;
         ST_WAIT: handoff = !o_valid_q || o_ready;
         default: ;
      endcase
   end

   // ---------------- datapath next-state ----------------
   always_comb begin
      cnt_d = cnt_q;
      if (xfer) cnt_d = cell_done ? '0 : cnt_q + 1'b1;

      s1_vld_d = xfer;
      s1_bin_d = xfer ? bin_w : s1_bin_q;
      s1_mag_d = xfer ? i_mag : s1_mag_q;

      o_hist_d = o_hist_q;
      for (int k = 0; k < NUM_BINS; k++) begin
         acc_sum[k] = acc_q[k] + ((s1_vld_q && (s1_bin_q == BIN_W'(k))) ? mag_ext : '0);
         acc_d[k]   = handoff ? '0 : acc_sum[k];
         if (handoff) o_hist_d[k*ACC_W +: ACC_W] = acc_sum[k];
      end

      if (handoff)      o_valid_d = 1'b1;
      else if (o_ready) o_valid_d = 1'b0;
      else              o_valid_d = o_valid_q;

      o_drop_d = o_drop_q || (i_valid && !i_ready);
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         s1_vld_q  <= 1'b0;
         s1_bin_q  <= '0;
         s1_mag_q  <= '0;
         o_hist_q  <= '0;
         o_valid_q <= 1'b0;
         o_drop_q  <= 1'b0;
         for (int k = 0; k < NUM_BINS; k++) acc_q[k] <= '0;
      end else begin
         cnt_q     <= cnt_d;
         s1_vld_q  <= s1_vld_d;
         s1_bin_q  <= s1_bin_d;
         s1_mag_q  <= s1_mag_d;
         o_hist_q  <= o_hist_d;
         o_valid_q <= o_valid_d;
         o_drop_q  <= o_drop_d;
         for (int k = 0; k < NUM_BINS; k++) acc_q[k] <= acc_d[k];
      end
   end

   assign o_hist  = o_hist_q;
   assign o_valid = o_valid_q;
   assign o_drop  = o_drop_q;

endmodule

// File: tb/tb_hog_bin_accum.sv
// Directed + randomized bench for hog_bin_accum with a behavioural histogram model.
module tb_hog_bin_accum;

   localparam int ACC_W = 24;
   localparam int NB    = 9;
   localparam int HW    = NB * ACC_W;
   localparam int CELL  = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_ready;
   logic [19:0]   i_tan = '0;
   logic [15:0]   i_mag = '0;
   logic          o_valid;
   logic          o_ready = 1'b1;
   logic [HW-1:0] o_hist;
   logic          o_drop;

   hog_bin_accum dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_tan   (i_tan),
      .i_mag   (i_mag),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_hist  (o_hist),
      .o_drop  (o_drop)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // model: running histogram of the current cell and completed cells in order
   int            mdl [NB];
   int            mdl_cnt = 0;
   logic [HW-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Bin = how many bin edges the angle has passed, counted from 0 deg for
   // t>=0 and from 80 deg (the negative clamp) for t<0.
   function automatic int ref_bin(input logic [19:0] t);
      int v;
      int b;
      int pos [4];
      int neg [4];
      pos = '{32'h05D2D, 32'h0D6D0, 32'h1BB68, 32'h5ABD9};
      neg = '{32'hA5426 - 32'h100000, 32'hE4498 - 32'h100000,
              32'hF2930 - 32'h100000, 32'hFA2D3 - 32'h100000};
      v = $signed(t);
      if (v >= 0) begin
         b = 0;
         for (int i = 0; i < 4; i++) if (v >= pos[i]) b++;
      end else begin
         b = 4;
         for (int i = 0; i < 4; i++) if (v > neg[i]) b++;
      end
      return b;
   endfunction

   function automatic logic [HW-1:0] pack_mdl();
      logic [HW-1:0] r;
      r = '0;
      for (int k = 0; k < NB; k++) r[k*ACC_W +: ACC_W] = 24'(mdl[k]);
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NB; k++) mdl[k] = 0;
      mdl_cnt = 0;
   endtask

   task automatic model_add(input logic [19:0] t, input logic [15:0] m);
      mdl[ref_bin(t)] += int'(m);
      mdl_cnt++;
      if (mdl_cnt == CELL) begin
         exp_q.push_back(pack_mdl());
         model_clear();
      end
   endtask

   function automatic logic [19:0] rand_tan();
      int r;
      r = int'($urandom_range(32'hB57B3, 0)) - 32'h5ABDA;
      return r[19:0];
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!i_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!i_ready) begin
         tests++;
         fails++;
         $error("FAIL wait_ready timeout observed=0 expected=1");
      end
   endtask

   task automatic wait_ovalid();
      int n = 0;
      while (!o_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!o_valid) begin
         tests++;
         fails++;
         $error("FAIL wait_ovalid timeout observed=0 expected=1");
      end
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send(input logic [19:0] t, input logic [15:0] m);
      wait_ready();
      i_valid = 1'b1;
      i_tan   = t;
      i_mag   = m;
      @(negedge clk);
      i_valid = 1'b0;
      model_add(t, m);
   endtask

   task automatic check_front(input string tag);
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL %s observed=histogram expected=none_pending", tag);
      end else begin
         tests--;
         chk(tag, o_hist, exp_q.pop_front());
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [HW-1:0] e;
      logic [HW-1:0] hist_a;
      logic [19:0]   bnd [8];

      model_clear();

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk1("rst_i_ready", i_ready, 1'b0);
      chk1("rst_o_valid", o_valid, 1'b0);
      chk1("rst_o_drop", o_drop, 1'b0);
      chk("rst_o_hist", o_hist, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("post_rst_i_ready", i_ready, 1'b1);

      // ---- 64 x (tan 0, mag 1): latency and bin 0 ----
      for (int i = 0; i < CELL; i++) send(20'h00000, 16'd1);
      chk1("lat_t1_o_valid", o_valid, 1'b0);
      chk1("lat_t1_i_ready", i_ready, 1'b0);
      @(negedge clk);
      chk1("lat_t2_o_valid", o_valid, 1'b1);
      chk1("lat_t2_i_ready", i_ready, 1'b1);
      e = '0;
      e[0 +: ACC_W] = 24'd64;
      chk("zero_tan_const", o_hist, e);
      check_front("zero_tan_model");
      @(negedge clk);
      chk1("o_valid_drop", o_valid, 1'b0);

      // ---- boundary sweep, remaining pixels carry mag 0 ----
      bnd = '{20'h05D2C, 20'h05D2D, 20'h5ABD9, 20'hA5426,
              20'hE4498, 20'hE4499, 20'hFA2D3, 20'hFFFFF};
      for (int i = 0; i < 8; i++) send(bnd[i], 16'd1);
      for (int i = 8; i < CELL; i++) send(rand_tan(), 16'd0);
      wait_ovalid();
      e = '0;
      e[0*ACC_W +: ACC_W] = 24'd1;
      e[1*ACC_W +: ACC_W] = 24'd1;
      e[4*ACC_W +: ACC_W] = 24'd2;
      e[5*ACC_W +: ACC_W] = 24'd1;
      e[6*ACC_W +: ACC_W] = 24'd1;
      e[7*ACC_W +: ACC_W] = 24'd1;
      e[8*ACC_W +: ACC_W] = 24'd1;
      chk("boundary_const", o_hist, e);
      check_front("boundary_model");
      @(negedge clk);

      // ---- random cells ----
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < CELL; i++) send(rand_tan(), 16'($urandom_range(16'hFFFF, 0)));
         wait_ovalid();
         check_front($sformatf("random_cell%0d", c));
         @(negedge clk);
      end

      // ---- full-scale magnitude into bin 2 ----
      for (int i = 0; i < CELL; i++) send(20'h10000, 16'hFFFF);
      wait_ovalid();
      e = '0;
      e[2*ACC_W +: ACC_W] = 24'h3FFFC0;
      chk("max_mag_const", o_hist, e);
      check_front("max_mag_model");
      @(negedge clk);

      // ---- back-pressure across two cells, then dropped samples ----
      o_ready = 1'b0;
      for (int i = 0; i < CELL; i++) send(rand_tan(), 16'($urandom_range(16'hFFFF, 0)));
      wait_ovalid();
      hist_a = exp_q[0];
      chk("bp_first_hist", o_hist, hist_a);
      for (int i = 0; i < CELL; i++) send(rand_tan(), 16'($urandom_range(16'hFFFF, 0)));
      repeat (4) @(negedge clk);
      chk1("bp_i_ready_low", i_ready, 1'b0);
      chk1("bp_o_valid_held", o_valid, 1'b1);
      chk("bp_first_hist_stable", o_hist, hist_a);
      i_valid = 1'b1;
      i_tan   = 20'h00000;
      i_mag   = 16'hFFFF;
      repeat (3) @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      chk1("drop_set", o_drop, 1'b1);
      chk("drop_hist_unchanged", o_hist, hist_a);
      o_ready = 1'b1;
      @(negedge clk);
      void'(exp_q.pop_front());
      chk1("bp_release_o_valid", o_valid, 1'b1);
      check_front("bp_second_hist");
      chk1("bp_release_i_ready", i_ready, 1'b1);
      @(negedge clk);
      chk1("bp_o_valid_drop", o_valid, 1'b0);
      chk1("drop_sticky", o_drop, 1'b1);

      // ---- reset mid-cell discards the partial histogram ----
      for (int i = 0; i < 30; i++) send(rand_tan(), 16'($urandom_range(16'hFFFF, 0)));
      rst_n = 1'b0;
      #1;
      chk1("midrst_i_ready", i_ready, 1'b0);
      chk1("midrst_o_valid", o_valid, 1'b0);
      chk1("midrst_o_drop", o_drop, 1'b0);
      chk("midrst_o_hist", o_hist, '0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < CELL; i++) send(20'h20000, 16'd2);
      wait_ovalid();
      e = '0;
      e[3*ACC_W +: ACC_W] = 24'd128;
      chk("after_rst_const", o_hist, e);
      check_front("after_rst_model");
      chk1("after_rst_no_drop", o_drop, 1'b0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
